// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: ROM bus and decode handshake for the fetch sequencer.
//
// Signals
//   imem_addr      sequencer -> ROM     ROM address (the sequencer's PC)
//   imem_rd        ROM -> sequencer     combinational ROM read data
//   instr_out      sequencer -> decode  registered instruction word
//   instr_valid    sequencer -> decode  instr_out holds a word for decode
//   instr_ready    decode -> sequencer  decode takes instr_out this cycle
//   redirect_en    decode -> sequencer  on accept, jump to redirect_addr
//   redirect_addr  decode -> sequencer  jump target
//
// Handshake: a word transfers on a rising edge where instr_valid and
// instr_ready are both 1. Once instr_valid rises, instr_out stays constant
// and instr_valid stays high until that transfer (only reset withdraws it).
// instr_ready may change freely and does not depend on instr_valid.
// redirect_en/redirect_addr matter only on the transfer edge.
//
// Modports: master = sequencer side, slave = ROM + decode side.

interface fetch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rd;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_addr;

  modport master (
    output imem_addr,
    input  imem_rd,
    output instr_out,
    output instr_valid,
    input  instr_ready,
    input  redirect_en,
    input  redirect_addr
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    output redirect_en,
    output redirect_addr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives a combinational instruction ROM, registers each
// word and hands it to decode over a valid/ready handshake. Supports
// free-run and single-step operation, PC redirect on accept, and halting at
// end of program (after LAST_ADDR is accepted, or on an all-zero word).
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   start        in   begin (from HALT, restarting at PC 0) or resume (from IDLE)
//   step_mode    in   1: return to IDLE after every accepted instruction
//   bus          master modport of fetch_sequencer_if (ROM + decode)
//   halted       out  sequencer is in HALT
//   fetch_count  out  accepted instructions since reset/restart, saturating
//   state_dbg    out  current FSM state, for observation only

module fetch_sequencer #(
  parameter int              ADDR_W       = 8,
  parameter int              DATA_W       = 32,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}},
  parameter int              HALT_ON_ZERO = 1,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  fetch_sequencer_if.master bus,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                accept;
  logic                zero_word;
  logic [ADDR_W-1:0]   pc_inc;
  logic [CNT_W-1:0]    count_inc;

  // Only meaningful in HOLD: that is the only state with a word on offer.
  assign accept    = (state_q == HOLD) && bus.instr_ready;
  assign zero_word = (HALT_ON_ZERO != 0) && (bus.imem_rd == '0);
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        // Resume from wherever the PC was left.
        if (start) state_d = FETCH;
      end

      FETCH: begin
        if (zero_word) begin
          // End-of-program marker: not delivered, PC stays on it.
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          instr_d = bus.imem_rd;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (accept) begin
          valid_d = 1'b0;
          count_d = count_inc;
          pc_d    = bus.redirect_en ? bus.redirect_addr : pc_inc;
          // Falling off LAST_ADDR halts even in step mode; a redirect from
          // LAST_ADDR keeps the program alive.
          if (!bus.redirect_en && (pc_q == LAST_ADDR)) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else if (step_mode) begin
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end

      HALT: begin
        if (start) begin
          pc_d     = '0;
          count_d  = '0;
          halted_d = 1'b0;
          state_d  = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign halted          = halted_q;
  assign fetch_count     = count_q;
  assign state_dbg       = state_q;

endmodule
